// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store initiator with read-modify-write for byte/half stores
module lsu_mem_ctrl #(
    parameter int DATA_W        = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misalign
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] rmw_buf;
    logic [DATA_W-1:0] rmw_addr;

    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              illegal;
    logic              unaligned;
    logic              go;
    logic [1:0]        off;
    logic [4:0]        shift;
    logic [DATA_W-1:0] word_addr;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] ext_data;
    logic              sgn;

    // Decode width, legality, alignment and the byte lane; build load extension and store merge
    always_comb begin
        is_byte   = (funct3[1:0] == 2'b00);
        is_half   = (funct3[1:0] == 2'b01);
        is_word   = (funct3[1:0] == 2'b10);
        // Loads: 011/110/111 are undefined; stores only have SB/SH/SW
        illegal   = req_we ? (funct3[2] || funct3[1:0] == 2'b11)
                           : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
        unaligned = (is_word && addr[1:0] != 2'b00) || (is_half && addr[0]);
        // Forcing offending low bits to zero keeps the non-trapping variant usable
        if (is_word)
            off = 2'b00;
        else if (is_half)
            off = {addr[1], 1'b0};
        else
            off = addr[1:0];
        shift     = {off, 3'b000};
        word_addr = {addr[DATA_W-1:2], 2'b00};
        lane_data = mem_rdata >> shift;
        sgn       = 1'b0;
        ext_data  = mem_rdata;
        if (is_byte) begin
            sgn      = ~funct3[2] & lane_data[7];
            ext_data = {{(DATA_W-8){sgn}}, lane_data[7:0]};
        end else if (is_half) begin
            sgn      = ~funct3[2] & lane_data[15];
            ext_data = {{(DATA_W-16){sgn}}, lane_data[15:0]};
        end
        lane_mask = is_byte ? (DATA_W'(8'hFF) << shift) : (DATA_W'(16'hFFFF) << shift);
        merged    = (mem_rdata & ~lane_mask) | ((wdata << shift) & lane_mask);
        go        = req_valid && !illegal && !(MISALIGN_TRAP && unaligned);
    end

    // State register and RMW capture of the merged word at the end of the read cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rmw_buf  <= '0;
            rmw_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == RMW_WR) begin
                rmw_buf  <= merged;
                rmw_addr <= word_addr;
            end
        end
    end

    // Next-state and memory/pipeline outputs; everything held at zero while in reset
    always_comb begin
        state_nxt    = state;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        load_data    = '0;
        stall        = 1'b0;
        misalign     = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = word_addr;
                if (req_valid)
                    misalign = illegal || unaligned;
                if (go) begin
                    if (!req_we) begin
                        mem_read_en = 1'b1;
                        load_data   = ext_data;
                    end else if (is_word) begin
                        mem_write_en = 1'b1;
                        mem_wdata    = wdata;
                    end else begin
                        mem_read_en = 1'b1;
                        stall       = 1'b1;
                        state_nxt   = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // The still-presented instruction is ignored; only the captured word is written
                mem_write_en = 1'b1;
                mem_addr     = rmw_addr;
                mem_wdata    = rmw_buf;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rstn) begin
            mem_addr     = '0;
            mem_wdata    = '0;
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            load_data    = '0;
            stall        = 1'b0;
            misalign     = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a word-addressed memory model
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;

    logic [31:0] mem [0:63];

    int n_checks;
    int n_fail;
    int vec_id;

    typedef struct {
        int          id;
        logic [31:0] ld;
        logic [31:0] ma;
        logic [31:0] wd;
        logic        st;
        logic        mis;
        logic        rd;
        logic        wr;
        logic        cma;
        logic        cwd;
    } exp_t;

    exp_t exp_q[$];

    lsu_mem_ctrl #(.DATA_W(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .load_data    (load_data),
        .stall        (stall),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read, synchronous write memory
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write_en)
            mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.id, "load_data", load_data, e.ld);
            chk(e.id, "stall", {31'd0, stall}, {31'd0, e.st});
            chk(e.id, "misalign", {31'd0, misalign}, {31'd0, e.mis});
            chk(e.id, "mem_read_en", {31'd0, mem_read_en}, {31'd0, e.rd});
            chk(e.id, "mem_write_en", {31'd0, mem_write_en}, {31'd0, e.wr});
            chk(e.id, "rd_wr_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
            if (e.cma) chk(e.id, "mem_addr", mem_addr, e.ma);
            if (e.cwd) chk(e.id, "mem_wdata", mem_wdata, e.wd);
        end
    end

    // Apply one cycle of stimulus and queue the hand-computed response
    task automatic cyc(input logic rv, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_ld, input logic e_st, input logic e_mis,
                       input logic e_rd, input logic e_wr,
                       input logic c_ma, input logic [31:0] e_ma,
                       input logic c_wd, input logic [31:0] e_wd);
        exp_t e;
        @(posedge clk);
        #1;
        rstn      = rv;
        req_valid = v;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        vec_id++;
        e.id  = vec_id;
        e.ld  = e_ld;
        e.st  = e_st;
        e.mis = e_mis;
        e.rd  = e_rd;
        e.wr  = e_wr;
        e.cma = c_ma;
        e.ma  = e_ma;
        e.cwd = c_wd;
        e.wd  = e_wd;
        exp_q.push_back(e);
    endtask

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        vec_id    = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = '0;
        wdata     = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8899AABB;
        mem[12] = 32'hA5A5A5A5;

        //   rstn v  we f3     addr          wdata         ld            st   mis  rd   wr   cma  ma            cwd  wd
        cyc(1'b0, 1, 0, LW,    32'h10,       32'h0,        32'h0,        0,   0,   0,   0,   1,   32'h0,        1,   32'h0);
        // Loads on word 0x8899AABB
        cyc(1'b1, 1, 0, LB,    32'h11,       32'h0,        32'hFFFFFFAA, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LBU,   32'h11,       32'h0,        32'h000000AA, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LH,    32'h12,       32'h0,        32'hFFFF8899, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LHU,   32'h12,       32'h0,        32'h00008899, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LW,    32'h10,       32'h0,        32'h8899AABB, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LB,    32'h13,       32'h0,        32'hFFFFFF88, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LB,    32'h10,       32'h0,        32'hFFFFFFBB, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        cyc(1'b1, 1, 0, LH,    32'h10,       32'h0,        32'hFFFFAABB, 0,   0,   1,   0,   1,   32'h10,       0,   32'h0);
        // SW then readback
        cyc(1'b1, 1, 1, SW,    32'h20,       32'h12345678, 32'h0,        0,   0,   0,   1,   1,   32'h20,       1,   32'h12345678);
        cyc(1'b1, 1, 0, LW,    32'h20,       32'h0,        32'h12345678, 0,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        // SB read-modify-write: cycle 1 read+stall, cycle 2 merged write
        cyc(1'b1, 1, 1, SB,    32'h22,       32'h111111CD, 32'h0,        1,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        cyc(1'b1, 1, 1, SB,    32'h22,       32'h111111CD, 32'h0,        0,   0,   0,   1,   1,   32'h20,       1,   32'h12CD5678);
        cyc(1'b1, 1, 0, LW,    32'h20,       32'h0,        32'h12CD5678, 0,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        // SH lower half
        cyc(1'b1, 1, 1, SH,    32'h20,       32'h0000BEEF, 32'h0,        1,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        cyc(1'b1, 1, 1, SH,    32'h20,       32'h0000BEEF, 32'h0,        0,   0,   0,   1,   1,   32'h20,       1,   32'h12CDBEEF);
        cyc(1'b1, 1, 0, LW,    32'h20,       32'h0,        32'h12CDBEEF, 0,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        // Misaligned SH is trapped, memory unchanged
        cyc(1'b1, 1, 1, SH,    32'h21,       32'h00001111, 32'h0,        0,   1,   0,   0,   0,   32'h0,        0,   32'h0);
        cyc(1'b1, 1, 0, LW,    32'h20,       32'h0,        32'h12CDBEEF, 0,   0,   1,   0,   1,   32'h20,       0,   32'h0);
        // Misaligned LW and illegal funct3 codes
        cyc(1'b1, 1, 0, LW,    32'h13,       32'h0,        32'h0,        0,   1,   0,   0,   0,   32'h0,        0,   32'h0);
        cyc(1'b1, 1, 0, 3'b011, 32'h10,      32'h0,        32'h0,        0,   1,   0,   0,   0,   32'h0,        0,   32'h0);
        cyc(1'b1, 1, 0, 3'b110, 32'h10,      32'h0,        32'h0,        0,   1,   0,   0,   0,   32'h0,        0,   32'h0);
        cyc(1'b1, 1, 1, 3'b100, 32'h20,      32'h0,        32'h0,        0,   1,   0,   0,   0,   32'h0,        0,   32'h0);
        // Idle with no request
        cyc(1'b1, 0, 0, LW,    32'h13,       32'h0,        32'h0,        0,   0,   0,   0,   0,   32'h0,        0,   32'h0);
        // Reset during RMW_WR of SB at 0x30 drops the write
        cyc(1'b1, 1, 1, SB,    32'h30,       32'h00000077, 32'h0,        1,   0,   1,   0,   1,   32'h30,       0,   32'h0);
        cyc(1'b0, 1, 1, SB,    32'h30,       32'h00000077, 32'h0,        0,   0,   0,   0,   1,   32'h0,        1,   32'h0);
        cyc(1'b1, 0, 0, LW,    32'h30,       32'h0,        32'h0,        0,   0,   0,   0,   0,   32'h0,        0,   32'h0);
        cyc(1'b1, 1, 0, LW,    32'h30,       32'h0,        32'hA5A5A5A5, 0,   0,   1,   0,   1,   32'h30,       0,   32'h0);

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(0, "scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
MEM-stage load/store initiator that drives the word-addressed data memory: combinational-read port, synchronous write, no byte enables.
- Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses and extracts/extends load data.
- Implements SB/SH as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Detects misaligned accesses.

Parameters:
DATA_W, 32, data/address width (equals CPU_WIDTH).
MISALIGN_TRAP, 1, 1: misaligned accesses suppressed and flagged; 0: low address bits forced to alignment, access proceeds, flag still raised.

Ports:
clk  in  1  pipeline clock.
rstn  in  1  asynchronous active-low reset.
req_valid  in  1  MEM stage holds a load/store this cycle.
req_we  in  1  1 = store, 0 = load.
funct3  in  3  RV32I width/sign code.
addr  in  DATA_W  byte address from ALU.
wdata  in  DATA_W  store data (rs2), LSB-aligned.
mem_rdata  in  DATA_W  data memory read word.
mem_addr  out  DATA_W  word-aligned byte address to memory, {addr[31:2],2'b00}.
mem_wdata  out  DATA_W  full word to write.
mem_read_en  out  1  memory read enable.
mem_write_en  out  1  memory write enable, sampled at posedge clk.
load_data  out  DATA_W  extended load result to WB.
stall  out  1  hold IF/ID/EX/MEM registers this cycle.
misalign  out  1  misaligned or illegal-funct3 access this cycle.

Behaviour:
- Reset: asynchronous on rstn low. state=IDLE, rmw_buf=0, rmw_addr=0. All outputs 0 while rstn low.
- FSM states: IDLE, RMW_WR.
- IDLE, no req_valid: all enables 0, stall 0, load_data 0, misalign 0.
- IDLE, load: mem_read_en=1; load_data is combinational from mem_rdata in the same cycle (0-cycle latency); stall 0. Little-endian lane selection:
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword addr[1], sign- or zero-extended.
  - LW: full word.
- IDLE, SW: mem_write_en=1, mem_wdata=wdata; write commits at the next edge; stall 0.
- IDLE, SB/SH (cycle 1):
  - mem_read_en=1, stall=1.
  - At the edge: rmw_buf <= mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]; rmw_addr <= mem_addr; state <= RMW_WR.
- RMW_WR (cycle 2):
  - mem_write_en=1, mem_addr=rmw_addr, mem_wdata=rmw_buf; stall 0; mem_read_en 0; load_data 0.
  - The request inputs (same instruction still presented) are ignored.
  - Next state IDLE unconditionally.
- Misalignment: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0, raises misalign=1 combinationally in IDLE.
  - MISALIGN_TRAP=1: no enables asserted, load_data 0, no RMW started.
  - MISALIGN_TRAP=0: offending low bits treated as 0, access proceeds.
- Illegal funct3 (011, 110, 111, or store funct3 >= 011): misalign=1, no access, load_data 0, regardless of MISALIGN_TRAP.
- mem_read_en and mem_write_en are never both 1 in the same cycle.
- Back-to-back SB then load: the load is presented only after RMW_WR, so it observes the merged word.
- Reset during RMW_WR: the write is dropped, state returns to IDLE, memory is unchanged.
- Total store cost: SW 1 cycle, SB/SH 2 cycles; loads 1 cycle.

Test Plan:
- mem word @0x10=0x8899AABB; LB addr 0x11 -> load_data=0xFFFFFFAA; LBU -> 0x000000AA; LH addr 0x12 -> 0xFFFF8899; LHU -> 0x00008899; LW 0x10 -> 0x8899AABB; stall 0 throughout.
- SW addr 0x20 wdata 0x12345678 -> mem_write_en 1 for one cycle, mem_addr 0x20; subsequent LW 0x20 returns 0x12345678.
- mem @0x20=0x12345678; SB addr 0x22 wdata 0xCD -> stall=1 in cycle 1, mem_read_en=1; cycle 2 mem_write_en=1, mem_wdata=0x12CD5678, stall 0; memory reads back 0x12CD5678.
- SH addr 0x20 wdata 0xBEEF on word 0x12CD5678 -> stored 0x12CDBEEF; SH addr 0x21 with MISALIGN_TRAP=1 -> misalign=1, no enables, memory unchanged.
- LW addr 0x13 -> misalign=1, load_data 0, mem_read_en 0; funct3=3'b011 load -> misalign=1, no access.
- Assert rstn low during RMW_WR of SB addr 0x30 -> mem_write_en 0, word @0x30 unchanged, state IDLE, stall 0 after release.
